cc_egr_monitor_protocol_v2: RTL and testbench

Parametrised native-RTL protocol monitor for the chain-control egress path. It passively observes the req/resp descriptor streams and the data stream between the egress scheduler and its consumer. It tracks outstanding requests and data credit, and flags protocol violations on a 16-bit per-cycle error vector plus a sticky register. It replaces the fixed-width, HLS-core monitor and sits alongside each egress port as a debug/safety tap with no back-pressure.

---
 rtl/cc_egr_monitor_pkg.sv | 34 +++
 rtl/cc_egr_monitor_req_fifo.sv | 62 ++++++
 rtl/cc_egr_monitor_protocol_v2.sv | 166 ++++++++++++++++
 tb/tb_cc_egr_monitor_protocol_v2.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_egr_monitor_pkg.sv
// Purpose: shared descriptor field offsets, fault bit indices and outstanding-entry type for the egress monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_egr_monitor_pkg;

  // Descriptor field layout (identical for req and resp)
  localparam int BL_LSB  = 48;
  localparam int BL_W    = 16;
  localparam int CH_LSB  = 16;
  localparam int CH_W    = 16;
  localparam int EOF_BIT = 1;
  localparam int SOF_BIT = 0;

  // Fault vector bit positions
  localparam int F_CH_MISMATCH  = 0;
  localparam int F_LEN_OVERRUN  = 1;
  localparam int F_SOF_MISMATCH = 2;
  localparam int F_EOF_MISMATCH = 3;
  localparam int F_REQ_ZERO     = 4;
  localparam int F_REQ_TOO_LONG = 5;
  localparam int F_REQ_OVERFLOW = 6;
  localparam int F_RESP_ORPHAN  = 7;
  localparam int F_DATA_NO_CRED = 8;
  localparam int F_UNSTABLE     = 9;

  // One accepted-but-unanswered request
  typedef struct packed {
    logic [CH_W-1:0] channel;
    logic            sof;
    logic            eof;
    logic [BL_W-1:0] remaining;
  } out_entry_t;

endpackage

// File: rtl/cc_egr_monitor_req_fifo.sv
// Purpose: outstanding-request FIFO with head peek, head remaining write-back and per-entry "first resp seen" flag.
// Latency: push/pop/write-back visible at head the cycle after they are applied.
// Backpressure: none; caller must not push when full nor pop/write-back when empty.
import cc_egr_monitor_pkg::*;

module cc_egr_monitor_req_fifo #(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  out_entry_t      push_entry,
  input  logic            pop,
  input  logic            wb_en,
  input  logic [BL_W-1:0] wb_remaining,
  output out_entry_t      head,
  output logic            head_seen,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  out_entry_t         r_mem [DEPTH];
  logic [DEPTH-1:0]   r_seen;
  logic [AW-1:0]      r_rd;
  logic [AW-1:0]      r_wr;
  logic [AW:0]        r_cnt;

  assign head      = r_mem[r_rd];
  assign head_seen = r_seen[r_rd];
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);

  // Storage: new entries start unseen; a partial resp rewrites the head and marks it seen.
  // Push and write-back never hit the same slot: write-back needs a non-empty FIFO, push a non-full one.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr]  <= push_entry;
      r_seen[r_wr] <= 1'b0;
    end
    if (wb_en) begin
      r_mem[r_rd].remaining <= wb_remaining;
      r_seen[r_rd]          <= 1'b1;
    end
  end

  // Pointers and occupancy; reset empties the FIFO so stale storage is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop)  r_rd <= r_rd + AW'(1);
      if (push && !pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (pop && !push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cc_egr_monitor_protocol_v2.sv
// Purpose: passive req/resp/data protocol monitor for the egress path; optional stability check via CC_EGR_MON_STABILITY_CHECK_EN.
// Latency: faults from handshakes of cycle N appear on protocol_error/sticky/error_count at N+1; zero latency on the monitored path.
// Backpressure: none; observes only and never drives any tready.
import cc_egr_monitor_pkg::*;

module cc_egr_monitor_protocol_v2 #(
  parameter int DATA_W            = 512,
  parameter int DESC_W            = 64,
  parameter int OUTSTANDING_DEPTH = 16,
  parameter int MAX_BURST_LEN     = 32768
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              req_tvalid,
  input  logic              req_tready,
  input  logic [DESC_W-1:0] req_tdata,
  input  logic              resp_tvalid,
  input  logic              resp_tready,
  input  logic [DESC_W-1:0] resp_tdata,
  input  logic              data_tvalid,
  input  logic              data_tready,
  input  logic [DATA_W-1:0] data_tdata,
  input  logic              err_clear,
  output logic [15:0]       protocol_error,
  output logic              protocol_error_ap_vld,
  output logic [15:0]       protocol_error_sticky,
  output logic [31:0]       error_count
);

  localparam int BEAT_B  = DATA_W / 8;
  localparam int BEAT_SH = $clog2(BEAT_B);
  localparam int CRED_W  = $clog2(OUTSTANDING_DEPTH * (MAX_BURST_LEN / BEAT_B + 1)) + 1;
  localparam int SUM_W   = ((CRED_W > BL_W + 1) ? CRED_W : BL_W + 1) + 1;

  logic              w_req_hs, w_resp_hs, w_data_hs;
  logic [BL_W-1:0]   w_req_bl, w_resp_len, w_new_rem;
  logic              w_req_bad_len, w_push, w_resp_act, w_chk, w_pop, w_wb;
  out_entry_t        w_push_entry, w_head;
  logic              w_head_seen, w_full, w_empty;
  logic [BL_W:0]     w_add;
  logic [SUM_W-1:0]  w_sum, w_net;
  logic [CRED_W-1:0] r_credit;
  logic [15:0]       w_err;
  logic [31:0]       w_cnt_base;
  logic              w_stab;
  logic              w_unused;

  assign w_req_hs  = req_tvalid  & req_tready;
  assign w_resp_hs = resp_tvalid & resp_tready;
  assign w_data_hs = data_tvalid & data_tready;

  assign w_req_bl   = req_tdata[BL_LSB +: BL_W];
  assign w_resp_len = resp_tdata[BL_LSB +: BL_W];

  // Requests: only well-formed ones that fit are tracked
  assign w_req_bad_len = (w_req_bl == '0) ||
                         ({1'b0, w_req_bl} > (BL_W+1)'(MAX_BURST_LEN));
  assign w_push        = w_req_hs && !w_full && !w_req_bad_len;
  assign w_push_entry  = '{channel:   req_tdata[CH_LSB +: CH_W],
                           sof:       req_tdata[SOF_BIT],
                           eof:       req_tdata[EOF_BIT],
                           remaining: w_req_bl};

  // Responses are judged against the pre-push head, so a same-cycle req is never matched
  assign w_resp_act = w_resp_hs && (w_resp_len != '0);
  assign w_chk      = w_resp_act && !w_empty;
  assign w_new_rem  = (w_resp_len >= w_head.remaining) ? '0 : (w_head.remaining - w_resp_len);
  assign w_pop      = w_chk && (w_new_rem == '0);
  assign w_wb       = w_chk && (w_new_rem != '0);

  cc_egr_monitor_req_fifo #(
    .DEPTH (OUTSTANDING_DEPTH)
  ) u_req_fifo (
    .clk          (ap_clk),
    .rst_n        (ap_rst_n),
    .push         (w_push),
    .push_entry   (w_push_entry),
    .pop          (w_pop),
    .wb_en        (w_wb),
    .wb_remaining (w_new_rem),
    .head         (w_head),
    .head_seen    (w_head_seen),
    .full         (w_full),
    .empty        (w_empty)
  );

  // Credit: beats owed by matched responses, rounded up to whole beats; orphan resps grant nothing
  assign w_add = w_chk ? (BL_W+1)'(({1'b0, w_resp_len} + (BL_W+1)'(BEAT_B - 1)) >> BEAT_SH) : '0;
  assign w_sum = SUM_W'(r_credit) + SUM_W'(w_add);
  assign w_net = (w_data_hs && (w_sum != '0)) ? (w_sum - SUM_W'(1)) : w_sum;

  // Credit register, floored at zero and clamped at its width
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_credit <= '0;
    end else if (w_net > SUM_W'({CRED_W{1'b1}})) begin
      r_credit <= '1;
    end else begin
      r_credit <= w_net[CRED_W-1:0];
    end
  end

`ifdef CC_EGR_MON_STABILITY_CHECK_EN
  logic [2:0]        r_stall;
  logic [DESC_W-1:0] r_req_dat, r_resp_dat;
  logic [DATA_W-1:0] r_data_dat;

  // Remember which channels were stalled last cycle and what they were offering
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stall    <= '0;
      r_req_dat  <= '0;
      r_resp_dat <= '0;
      r_data_dat <= '0;
    end else begin
      r_stall    <= {data_tvalid & ~data_tready, resp_tvalid & ~resp_tready, req_tvalid & ~req_tready};
      r_req_dat  <= req_tdata;
      r_resp_dat <= resp_tdata;
      r_data_dat <= data_tdata;
    end
  end

  assign w_stab = (r_stall[0] && (!req_tvalid  || (req_tdata  != r_req_dat)))  ||
                  (r_stall[1] && (!resp_tvalid || (resp_tdata != r_resp_dat))) ||
                  (r_stall[2] && (!data_tvalid || (data_tdata != r_data_dat)));
`else
  assign w_stab = 1'b0;
`endif

  // Fields the monitor deliberately ignores
  assign w_unused = ^{req_tdata[47:32], req_tdata[15:2], resp_tdata[47:32], resp_tdata[15:2], data_tdata};

  // Per-cycle fault vector from this cycle's handshakes
  always_comb begin
    w_err                 = '0;
    w_err[F_CH_MISMATCH]  = w_chk && (resp_tdata[CH_LSB +: CH_W] != w_head.channel);
    w_err[F_LEN_OVERRUN]  = w_chk && (w_resp_len > w_head.remaining);
    w_err[F_SOF_MISMATCH] = w_chk && !w_head_seen && (resp_tdata[SOF_BIT] != w_head.sof);
    w_err[F_EOF_MISMATCH] = w_pop && (resp_tdata[EOF_BIT] != w_head.eof);
    w_err[F_REQ_ZERO]     = w_req_hs && (w_req_bl == '0);
    w_err[F_REQ_TOO_LONG] = w_req_hs && ({1'b0, w_req_bl} > (BL_W+1)'(MAX_BURST_LEN));
    w_err[F_REQ_OVERFLOW] = w_req_hs && w_full;
    w_err[F_RESP_ORPHAN]  = w_resp_act && w_empty;
    w_err[F_DATA_NO_CRED] = w_data_hs && (r_credit == '0);
    w_err[F_UNSTABLE]     = w_stab;
  end

  // A clear in the same cycle as a fault restarts the count at that fault
  assign w_cnt_base = err_clear ? '0 : error_count;

  // Registered reporting: per-cycle vector, sticky OR and saturating fault-cycle count
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      protocol_error        <= '0;
      protocol_error_ap_vld <= 1'b0;
      protocol_error_sticky <= '0;
      error_count           <= '0;
    end else begin
      protocol_error        <= w_err;
      protocol_error_ap_vld <= |w_err;
      protocol_error_sticky <= (err_clear ? 16'h0 : protocol_error_sticky) | w_err;
      error_count           <= ((|w_err) && (w_cnt_base != 32'hFFFF_FFFF)) ? (w_cnt_base + 32'd1) : w_cnt_base;
    end
  end

endmodule

// File: tb/tb_cc_egr_monitor_protocol_v2.sv
// Purpose: self-checking bench for cc_egr_monitor_protocol_v2 (scoreboard against a queue-based reference model).
// Latency: expects every cycle's faults one clock later.
// Backpressure: bench drives all tvalid/tready itself; honours CC_EGR_MON_STABILITY_CHECK_EN if defined.
module tb_cc_egr_monitor_protocol_v2;

  localparam int DATA_W = 512;
  localparam int DESC_W = 64;
  localparam int DEPTH  = 16;
  localparam int MAXB   = 32768;
  localparam int BEAT   = DATA_W / 8;
  localparam int CMAX   = (1 << ($clog2(DEPTH * (MAXB / BEAT + 1)) + 1)) - 1;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              req_tvalid, req_tready, resp_tvalid, resp_tready, data_tvalid, data_tready;
  logic [DESC_W-1:0] req_tdata, resp_tdata;
  logic [DATA_W-1:0] data_tdata;
  logic              err_clear;
  logic [15:0]       protocol_error, protocol_error_sticky;
  logic              protocol_error_ap_vld;
  logic [31:0]       error_count;

  always #5 ap_clk = ~ap_clk;

  cc_egr_monitor_protocol_v2 #(
    .DATA_W (DATA_W), .DESC_W (DESC_W), .OUTSTANDING_DEPTH (DEPTH), .MAX_BURST_LEN (MAXB)
  ) dut (
    .ap_clk (ap_clk), .ap_rst_n (ap_rst_n),
    .req_tvalid (req_tvalid), .req_tready (req_tready), .req_tdata (req_tdata),
    .resp_tvalid (resp_tvalid), .resp_tready (resp_tready), .resp_tdata (resp_tdata),
    .data_tvalid (data_tvalid), .data_tready (data_tready), .data_tdata (data_tdata),
    .err_clear (err_clear),
    .protocol_error (protocol_error), .protocol_error_ap_vld (protocol_error_ap_vld),
    .protocol_error_sticky (protocol_error_sticky), .error_count (error_count)
  );

  // Reference model state: list of open requests, beat credit, reporting registers
  typedef struct {
    int ch;
    bit sof;
    bit eof;
    int rem;
    bit seen;
  } ent_t;

  typedef struct {
    logic [15:0] err;
    logic [15:0] sticky;
    logic [31:0] cnt;
  } exp_t;

  ent_t              mq[$];
  exp_t              sb[$];
  int                credit;
  logic [15:0]       m_sticky;
  logic [31:0]       m_cnt;
  bit                p_stall[3];
  logic [63:0]       p_req, p_resp;
  logic [DATA_W-1:0] p_data;
  int                n_chk = 0;
  int                n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] desc(input int bl, input int ch, input bit eof, input bit sof);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[63:48] = bl[15:0];
    d[31:16] = ch[15:0];
    d[1]     = eof;
    d[0]     = sof;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    credit   = 0;
    m_sticky = '0;
    m_cnt    = '0;
    for (int i = 0; i < 3; i++) p_stall[i] = 1'b0;
    p_req = '0; p_resp = '0; p_data = '0;
  endtask

  // Apply the protocol rules to one cycle of stimulus and queue the expected outputs
  task automatic model(input bit rv, input bit rr, input logic [63:0] rd,
                       input bit sv, input bit sr, input logic [63:0] sd,
                       input bit dv, input bit dr, input logic [DATA_W-1:0] dd, input bit clr);
    logic [15:0] e;
    int          bl, len, add;
    bit          pushok;
    ent_t        ne;
    exp_t        x;
    e = '0; add = 0; pushok = 0;
    if (rv && rr) begin
      bl = int'(rd[63:48]);
      if (bl == 0) e[4] = 1'b1;
      if (bl > MAXB) e[5] = 1'b1;
      if (mq.size() == DEPTH) e[6] = 1'b1;
      pushok = (mq.size() < DEPTH) && (bl != 0) && (bl <= MAXB);
      ne.ch = int'(rd[31:16]); ne.sof = rd[0]; ne.eof = rd[1]; ne.rem = bl; ne.seen = 1'b0;
    end
    if (sv && sr) begin
      len = int'(sd[63:48]);
      if (len != 0) begin
        if (mq.size() == 0) begin
          e[7] = 1'b1;
        end else begin
          if (int'(sd[31:16]) != mq[0].ch) e[0] = 1'b1;
          if (len > mq[0].rem) e[1] = 1'b1;
          if (!mq[0].seen && (sd[0] != mq[0].sof)) e[2] = 1'b1;
          add = (len + BEAT - 1) / BEAT;
          if (len >= mq[0].rem) begin
            if (sd[1] != mq[0].eof) e[3] = 1'b1;
            void'(mq.pop_front());
          end else begin
            mq[0].rem  = mq[0].rem - len;
            mq[0].seen = 1'b1;
          end
        end
      end
    end
    if (dv && dr && credit == 0) e[8] = 1'b1;
    credit = credit + add - ((dv && dr) ? 1 : 0);
    if (credit < 0) credit = 0;
    if (credit > CMAX) credit = CMAX;
    if (pushok) mq.push_back(ne);
`ifdef CC_EGR_MON_STABILITY_CHECK_EN
    if ((p_stall[0] && (!rv || rd != p_req)) ||
        (p_stall[1] && (!sv || sd != p_resp)) ||
        (p_stall[2] && (!dv || dd != p_data))) e[9] = 1'b1;
`endif
    p_stall[0] = rv && !rr; p_stall[1] = sv && !sr; p_stall[2] = dv && !dr;
    p_req = rd; p_resp = sd; p_data = dd;
    if (clr) begin
      m_sticky = '0;
      m_cnt    = '0;
    end
    m_sticky = m_sticky | e;
    if (e != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    x.err = e; x.sticky = m_sticky; x.cnt = m_cnt;
    sb.push_back(x);
  endtask

  // One clock of stimulus: drive at negedge, record expectation, return just after the capturing edge
  task automatic cyc(input bit rv, input bit rr, input logic [63:0] rd,
                     input bit sv, input bit sr, input logic [63:0] sd,
                     input bit dv, input bit dr, input bit clr);
    logic [DATA_W-1:0] dd;
    @(negedge ap_clk);
    for (int i = 0; i < DATA_W / 32; i++) dd[i*32 +: 32] = $urandom;
    req_tvalid = rv;  req_tready = rr;  req_tdata = rd;
    resp_tvalid = sv; resp_tready = sr; resp_tdata = sd;
    data_tvalid = dv; data_tready = dr; data_tdata = dd;
    err_clear = clr;
    model(rv, rr, rd, sv, sr, sd, dv, dr, dd, clr);
    @(posedge ap_clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 1, '0, 0, 1, '0, 0, 1, 0);
  endtask

  // Monitor: every registered output is compared with the oldest queued expectation
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (ap_rst_n && sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        chk("err_vec", {16'h0, protocol_error}, {16'h0, x.err});
        chk("ap_vld", {31'h0, protocol_error_ap_vld}, {31'h0, (x.err != 0)});
        chk("sticky", {16'h0, protocol_error_sticky}, {16'h0, x.sticky});
        chk("count", error_count, x.cnt);
      end
    end
  end

  initial begin
    logic [63:0] da;
    ap_rst_n = 1'b0;
    req_tvalid = 0; req_tready = 0; req_tdata = '0;
    resp_tvalid = 0; resp_tready = 0; resp_tdata = '0;
    data_tvalid = 0; data_tready = 0; data_tdata = '0;
    err_clear = 0;
    model_reset();
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_err", {16'h0, protocol_error}, 32'h0);
    chk("rst_vld", {31'h0, protocol_error_ap_vld}, 32'h0);
    chk("rst_sticky", {16'h0, protocol_error_sticky}, 32'h0);
    chk("rst_count", error_count, 32'h0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Clean 256-byte transfer: one req, one resp, four 64-byte beats
    cyc(1, 1, desc(256, 3, 1, 1), 0, 1, '0, 0, 1, 0);
    cyc(0, 1, '0, 1, 1, desc(256, 3, 1, 1), 0, 1, 0);
    repeat (4) cyc(0, 1, '0, 0, 1, '0, 1, 1, 0);
    chk("clean_count", error_count, 32'h0);

    // Illegal request lengths
    cyc(1, 1, desc(0, 0, 1, 1), 0, 1, '0, 0, 1, 0);
    chk("req_len0", {16'h0, protocol_error}, 32'h0010);
    cyc(1, 1, desc(40000, 0, 1, 1), 0, 1, '0, 0, 1, 0);
    chk("req_long", {16'h0, protocol_error}, 32'h0020);
    chk("len_sticky", {16'h0, protocol_error_sticky}, 32'h0030);
    chk("len_count", error_count, 32'd2);
    cyc(0, 1, '0, 0, 1, '0, 0, 1, 1);

    // Fill the FIFO, overflow once, then drain
    for (int i = 0; i < 16; i++) cyc(1, 1, desc(64, 7, 1, 1), 0, 1, '0, 0, 1, 0);
    chk("fill16", {16'h0, protocol_error}, 32'h0);
    cyc(1, 1, desc(64, 7, 1, 1), 0, 1, '0, 0, 1, 0);
    chk("overflow", {16'h0, protocol_error}, 32'h0040);
    cyc(0, 1, '0, 1, 1, desc(64, 7, 1, 1), 0, 1, 0);
    chk("pop_after_full", {16'h0, protocol_error}, 32'h0);
    for (int i = 0; i < 15; i++) cyc(0, 1, '0, 1, 1, desc(64, 7, 1, 1), 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, '0, 0, 1, '0, 1, 1, 0);
    chk("drain_count", error_count, 32'd1);

    // Channel and length mismatch together; 192 bytes grants 3 beats
    cyc(1, 1, desc(128, 1, 1, 1), 0, 1, '0, 0, 1, 0);
    cyc(0, 1, '0, 1, 1, desc(192, 2, 1, 1), 0, 1, 0);
    chk("ch_len", {16'h0, protocol_error}, 32'h0003);
    repeat (3) cyc(0, 1, '0, 0, 1, '0, 1, 1, 0);
    chk("credit3", {16'h0, protocol_error}, 32'h0);

    // Beat without credit while clearing in the same cycle
    cyc(0, 1, '0, 0, 1, '0, 1, 1, 1);
    chk("nocred", {16'h0, protocol_error}, 32'h0100);
    chk("clr_sticky", {16'h0, protocol_error_sticky}, 32'h0100);
    chk("clr_count", error_count, 32'd1);

    // Stalled request whose data changes (only an ignored bit)
    da = desc(64, 0, 1, 1);
    cyc(1, 0, da, 0, 1, '0, 0, 1, 0);
    cyc(1, 1, da ^ 64'h4, 0, 1, '0, 0, 1, 0);
`ifdef CC_EGR_MON_STABILITY_CHECK_EN
    chk("stability", {16'h0, protocol_error}, 32'h0200);
`else
    chk("stability", {16'h0, protocol_error}, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      bit rv, rr, sv, sr, dv, dr, clr;
      int sel, bl, len, ch;
      logic [63:0] rd, sd;
      rv  = ($urandom_range(0, 9) < 4);
      rr  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 39);
      bl  = (sel == 0) ? 0 : (sel == 1) ? 40000 : (sel == 2) ? MAXB : $urandom_range(1, 1024);
      rd  = desc(bl, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      sv  = ($urandom_range(0, 1) == 1);
      sr  = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
        len = ($urandom_range(0, 1) == 1) ? mq[0].rem : $urandom_range(1, mq[0].rem);
        ch  = ($urandom_range(0, 9) == 0) ? (mq[0].ch ^ 1) : mq[0].ch;
        sd  = desc(len, ch,
                   (len == mq[0].rem) ? (mq[0].eof ^ ($urandom_range(0, 9) == 0)) : bit'($urandom_range(0, 1)),
                   mq[0].seen ? bit'($urandom_range(0, 1)) : (mq[0].sof ^ ($urandom_range(0, 9) == 0)));
      end else begin
        len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 512);
        sd  = desc(len, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      dv  = ($urandom_range(0, 1) == 1);
      dr  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      cyc(rv, rr, rd, sv, sr, sd, dv, dr, clr);
    end

    // Asynchronous reset with requests outstanding discards all tracking
    cyc(1, 1, desc(256, 5, 1, 1), 0, 1, '0, 1, 1, 0);
    idle();
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_err", {16'h0, protocol_error}, 32'h0);
    chk("arst_vld", {31'h0, protocol_error_ap_vld}, 32'h0);
    chk("arst_sticky", {16'h0, protocol_error_sticky}, 32'h0);
    chk("arst_count", error_count, 32'h0);
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    cyc(0, 1, '0, 1, 1, desc(256, 5, 1, 1), 0, 1, 0);
    chk("orphan_after_rst", {16'h0, protocol_error}, 32'h0080);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
